// File: rtl/kbd_latch.sv
// kbd_latch: keyboard-side endpoint of the CPU keyboard interface.
// Incoming ASCII bytes go into a small type-ahead FIFO. They are presented
// one at a time as an Apple-style KBD register (bit 7 = strobe), plus a
// KBDSTRB register whose bit 7 is an any-key-down flag. KBDCLR drops the
// strobe, and the next buffered key then loads on the following edge.
module kbd_latch #(
   parameter int DEPTH          = 4,
   parameter bit UPCASE         = 1'b1,
   parameter int KEYDOWN_CYCLES = 1024
) (
   input  logic       phi,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] KBD,
   output logic [7:0] KBDSTRB,
   input  logic       KBDCLR,
   output logic       overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int KW = $clog2(KEYDOWN_CYCLES);

   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [KW-1:0] KD_ONE    = KW'(1);
   localparam logic [KW-1:0] KD_RELOAD = KW'(KEYDOWN_CYCLES - 1);

   // Fold lower-case ASCII to upper case when UPCASE is enabled.
   function automatic logic [6:0] fold_case(input logic [6:0] c);
      logic [6:0] r;
      if (UPCASE && (c >= 7'h61) && (c <= 7'h7A)) begin
         r = c - 7'h20;
      end else begin
         r = c;
      end
      return r;
   endfunction

   // The state encoding doubles as the KBD strobe bit.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [6:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [KW-1:0]   kd_cnt;
   logic            kd_flag;
   logic [6:0]      char_reg;
   logic            push;
   logic            pop;
   logic            drop;
   logic [6:0]      char_in;

   // Ingest decode: fullness is judged on the pre-edge count only.
   always_comb begin
      char_in = fold_case(rx_data[6:0]);
      push    = rx_valid && (count < CNT_FULL);
      drop    = rx_valid && (count >= CNT_FULL);
   end

   // Latch FSM next-state: load the FIFO head when empty, wait for KBDCLR when full.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (count != {CW{1'b0}}) begin
               pop      = 1'b1;
               state_nx = ST_FULL;
            end else begin
               state_nx = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (KBDCLR) begin
               state_nx = ST_EMPTY;
            end else begin
               state_nx = ST_FULL;
            end
         end
         default: begin
            state_nx = ST_EMPTY;
         end
      endcase
   end

   // Latch FSM state register.
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   // Character register: takes the FIFO head on every pop and holds otherwise.
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         char_reg <= 7'h00;
      end else if (pop) begin
         char_reg <= mem[rd_ptr];
      end
   end

   // Type-ahead FIFO storage, pointers and occupancy count.
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 7'h00;
         end
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (push) begin
            mem[wr_ptr] <= char_in;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Overflow pulse for one cycle after a byte is dropped.
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
      end
   end

   // Any-key-down counter: reloaded by every received byte (even dropped ones).
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         kd_cnt <= {KW{1'b0}};
      end else if (rx_valid) begin
         kd_cnt <= KD_RELOAD;
      end else if (kd_cnt != {KW{1'b0}}) begin
         kd_cnt <= kd_cnt - KD_ONE;
      end
   end

   // Registered key-down flag, one cycle behind the counter.
   always_ff @(posedge phi or posedge rst) begin
      if (rst) begin
         kd_flag <= 1'b0;
      end else begin
         kd_flag <= (kd_cnt != {KW{1'b0}});
      end
   end

   assign KBD     = {(state == ST_FULL), char_reg};
   assign KBDSTRB = {kd_flag, char_reg};

endmodule

// File: tb/tb_kbd_latch.sv
// tb_kbd_latch: directed stimulus for kbd_latch. Expected KBD loads are queued
// when keys are sent, and a monitor pops and compares them whenever the strobe
// rises. The main sequence also makes direct checks of register values.
module tb_kbd_latch;

   logic       phi = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       KBDCLR = 1'b0;
   logic [7:0] KBD;
   logic [7:0] KBDSTRB;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         ovf_exp = 0;
   int         ovf_seen = 0;
   logic       prev_stb = 1'b0;
   logic       prev_ovf = 1'b0;

   kbd_latch #(.DEPTH(4), .UPCASE(1'b1), .KEYDOWN_CYCLES(1024)) dut (
      .phi      (phi),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .KBD      (KBD),
      .KBDSTRB  (KBDSTRB),
      .KBDCLR   (KBDCLR),
      .overflow (overflow)
   );

   always #5 phi = ~phi;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge phi);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit keep, input logic [7:0] e);
      rx_data  = d;
      rx_valid = 1'b1;
      if (keep) exp_q.push_back(e);
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic clr();
      KBDCLR = 1'b1;
      tick();
      KBDCLR = 1'b0;
   endtask

   // Scoreboard monitor: every strobe rise must match the oldest queued key.
   always @(negedge phi) begin
      if (rst) begin
         prev_stb = 1'b0;
         prev_ovf = 1'b0;
      end else begin
         if (KBD[7] && !prev_stb) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %02h expected no load", KBD);
            end else begin
               check8("sb_load", KBD, exp_q.pop_front());
            end
         end
         if (overflow) begin
            ovf_seen++;
            check_int("ovf_width", int'(prev_ovf), 0);
         end
         prev_stb = KBD[7];
         prev_ovf = overflow;
      end
   end

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge phi);
      #1;
      check8("reset_kbd", KBD, 8'h00);
      check8("reset_kbdstrb", KBDSTRB, 8'h00);
      check8("reset_ovf", {7'b0, overflow}, 8'h00);
      rst = 1'b0;
      tick();
      tick();
      check8("idle_kbd", KBD, 8'h00);

      // Single key with case folding and key-down timeout
      send(8'h61, 1'b1, 8'hC1);
      tick();
      check8("single_kbd", KBD, 8'hC1);
      check8("single_strb", KBDSTRB, 8'hC1);
      clr();
      check8("single_clr_kbd", KBD, 8'h41);
      check8("single_clr_strb", KBDSTRB, 8'hC1);
      repeat (1021) tick();
      check8("keydown_hold", KBDSTRB, 8'hC1);
      tick();
      check8("keydown_fall", KBDSTRB, 8'h41);

      // Type-ahead
      send(8'h31, 1'b1, 8'hB1);
      send(8'h32, 1'b1, 8'hB2);
      send(8'h33, 1'b1, 8'hB3);
      tick();
      check8("ta_first", KBD, 8'hB1);
      clr();
      check8("ta_gap1", KBD, 8'h31);
      tick();
      check8("ta_second", KBD, 8'hB2);
      clr();
      check8("ta_gap2", KBD, 8'h32);
      tick();
      check8("ta_third", KBD, 8'hB3);
      clr();
      check8("ta_clr3", KBD, 8'h33);
      repeat (3) tick();
      check8("ta_stay", KBD, 8'h33);

      // Overflow: latch full, five keys, fifth dropped
      send(8'h41, 1'b1, 8'hC1);
      tick();
      check8("ovf_latched", KBD, 8'hC1);
      for (int i = 0; i < 4; i++) begin
         send(8'(8'h35 + i), 1'b1, 8'(8'hB5 + i));
      end
      send(8'h39, 1'b0, 8'h00);
      ovf_exp++;
      check8("ovf_pulse", {7'b0, overflow}, 8'h01);
      tick();
      check8("ovf_end", {7'b0, overflow}, 8'h00);
      repeat (5) begin
         clr();
         tick();
      end
      check8("drain_last", KBD, 8'h38);

      // Simultaneous push/pop, KBDCLR held into a load, KBDCLR while empty
      send(8'h4A, 1'b1, 8'hCA);
      send(8'h4B, 1'b1, 8'hCB);
      tick();
      check8("sim_first", KBD, 8'hCA);
      KBDCLR = 1'b1;
      tick();
      check8("sim_clr", KBD, 8'h4A);
      tick();
      check8("sim_load_despite_clr", KBD, 8'hCB);
      KBDCLR = 1'b0;
      clr();
      check8("sim_clr2", KBD, 8'h4B);
      clr();
      check8("clr_in_empty", KBD, 8'h4B);
      tick();
      check8("clr_in_empty_hold", KBD, 8'h4B);

      // Pointer wrap, with bit 7 of rx_data set to show it is ignored
      for (int i = 0; i < 10; i++) begin
         send(8'(8'hC0 + i), 1'b1, 8'(8'hC0 + i));
         tick();
         clr();
      end
      check8("wrap_last", KBD, 8'h49);

      // Reset mid-operation with two keys buffered
      send(8'h58, 1'b1, 8'hD8);
      send(8'h59, 1'b0, 8'h00);
      send(8'h5A, 1'b0, 8'h00);
      tick();
      check8("pre_rst_kbd", KBD, 8'hD8);
      #2;
      rst = 1'b1;
      #1;
      check8("midrst_kbd", KBD, 8'h00);
      check8("midrst_strb", KBDSTRB, 8'h00);
      check8("midrst_ovf", {7'b0, overflow}, 8'h00);
      @(posedge phi);
      #1;
      rst = 1'b0;
      repeat (4) tick();
      check8("post_rst_kbd", KBD, 8'h00);
      check8("post_rst_strb", KBDSTRB, 8'h00);

      check_int("sb_empty", exp_q.size(), 0);
      check_int("ovf_count", ovf_seen, ovf_exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
